pipe_rr_sched: RTL
==================

Name: pipe_rr_sched

Overview:
Round-robin scheduler that shares one fixed-latency, single-enable datapath pipeline (LAT stages, common stage enable) among NREQ requesters. It selects one requester per advancing cycle, muxes that requester's operand into the pipeline, and tracks a valid bit plus requester tag alongside the data. It drives the pipeline's common enable and stalls the whole pipeline on per-requester response backpressure. It also returns each result to the requester that issued it.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, 2, tag width; must satisfy 2**IDW >= NREQ
DW, 16, operand/result width
LAT, 4, datapath latency in enabled cycles (>=1); must equal the external pipeline depth
MAX_OS, 2, per-requester in-flight cap (used only with PIPE_SCHED_OSCAP_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset: synchronous, active-low; clock i_clk
i_req  in  NREQ  per-requester request, level; bit k = requester k
i_data  in  NREQ*DW  operands; requester k at [k*DW +: DW]
o_gnt  out  NREQ  one-hot grant; operand k is captured at this edge
o_pipe_en  out  1  common enable to all datapath stages
o_pipe_d  out  DW  operand into datapath stage 0 (granted data, else 0)
i_pipe_q  in  DW  datapath output, aligned with tail stage
o_rsp_vld  out  NREQ  one-hot response valid
o_rsp_data  out  DW  = i_pipe_q
i_rsp_rdy  in  NREQ  per-requester response ready
i_drain  in  1  stop issuing and empty the pipeline
o_drained  out  1  drain state and all valid bits clear

Behaviour:
- Internal tracking shift register: LAT stages of {vld, tag[IDW-1:0]}, shifted only when o_pipe_en=1. Stage 0 loads {grant_any, granted index}.
- tail = stage LAT-1.
- o_pipe_en = !tail.vld | i_rsp_rdy[tail.tag]. Combinational; no dependency on i_req.
- o_rsp_vld = tail.vld ? (1 << tail.tag) : 0.
- A response transfers when o_rsp_vld[k] & i_rsp_rdy[k].
- Grant is combinational, issued only when o_pipe_en=1 and state=RUN.
  - Winner: first eligible requester at or after pointer ptr, searching upward with wrap NREQ-1 -> 0.
  - Eligible = i_req[k] (& cap-mask, see optional feature).
- o_gnt is zero when no grant. A bubble (vld=0) enters stage 0 on each enabled edge without a grant.
- ptr: reset 0. On a grant to k, ptr <= (k+1) mod NREQ. Otherwise ptr holds.
- Latency: grant in cycle t with no stalls -> o_rsp_vld in cycle t+LAT. Each stalled cycle adds 1.
- Full throughput: one grant per cycle while i_rsp_rdy stays high.
- Stall: tail valid with its target not ready -> o_pipe_en=0, no grants, all stages and ptr hold.
- Responses to other requesters never bypass the tail; responses stay in order.
- FSM states:
  - RUN: grants allowed. i_drain=1 -> DRAIN. No grant in the cycle i_drain is first seen.
  - DRAIN: no grants; pipeline keeps advancing and bubbles enter.
  - o_drained = (state==DRAIN) & no stage valid.
  - DRAIN with i_drain=0 -> RUN, even if not yet drained.
- Simultaneous events:
  - Response accept and new grant in the same cycle are legal; the shift and load happen together.
  - i_req may drop without being granted; no grant is remembered.
- Reset, including mid-operation: all vld=0, tags=0, ptr=0, state=RUN. In-flight operations are discarded.
- Outputs while reset is held or in the first cycle after reset: o_gnt=0 if i_req=0, o_rsp_vld=0, o_pipe_en=1, o_drained=0.

Optional Feature:
PIPE_SCHED_OSCAP_EN
- Defined:
  - Per-requester in-flight counters, width clog2(MAX_OS+1).
  - +1 on grant, -1 on response transfer, net 0 when both happen in the same cycle.
  - Requester k is ineligible while cnt[k]==MAX_OS.
  - Counters reset to 0.
- Undefined: no counters, no masking; eligibility = i_req only.

Test Plan:
1. Reset, then i_req=4'b1111, all rdy=1 -> grants 0,1,2,3,0,... one per cycle. o_rsp_vld to requester 0 appears 4 cycles after its grant; o_rsp_data matches i_pipe_q.
2. Only i_req[2]=1 for 6 cycles, LAT=4 -> six consecutive grants to 2, then responses in cycles 4..9. Bubbles visible as o_pipe_en=1 with o_gnt=0 after the requests end.
3. Tail tag=1 with i_rsp_rdy[1]=0 for 3 cycles -> o_pipe_en=0 and o_gnt=0 for 3 cycles; tracking state frozen. Response transfers on the cycle rdy rises.
4. Pipeline holding 3 valid entries, i_drain=1, rdy=1 -> no grants; o_drained=1 exactly when the last entry leaves the tail. Drop i_drain -> grants resume the next cycle.
5. Assert i_rst_n=0 while 4 entries are in flight -> next cycle o_rsp_vld=0 and ptr=0; first grant after reset goes to the lowest requesting index.
6. With PIPE_SCHED_OSCAP_EN, MAX_OS=2, only i_req[0]=1, rdy[0]=0 -> exactly 2 grants, then none. After one response transfers, exactly one more grant.

Source files
------------

// File: rtl/pipe_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency, common-enable datapath among NREQ requesters.
// Define PIPE_SCHED_OSCAP_EN to cap each requester at MAX_OS operations in flight.
module pipe_rr_sched #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int DW     = 16,
    parameter int LAT    = 4,
    parameter int MAX_OS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*DW-1:0]   i_data,
    output logic [NREQ-1:0]      o_gnt,
    output logic                 o_pipe_en,
    output logic [DW-1:0]        o_pipe_d,
    input  logic [DW-1:0]        i_pipe_q,
    output logic [NREQ-1:0]      o_rsp_vld,
    output logic [DW-1:0]        o_rsp_data,
    input  logic [NREQ-1:0]      i_rsp_rdy,
    input  logic                 i_drain,
    output logic                 o_drained
);

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t          state;
    logic [LAT-1:0]  stg_vld;
    logic [IDW-1:0]  stg_tag [LAT];
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] cap_mask;
    logic [NREQ-1:0] eligible;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  cand;
    logic            win_found;
    logic            grant_ok;
    logic            tail_vld;
    logic [IDW-1:0]  tail_tag;

    if (NREQ < 2 || NREQ > 16 || (2 ** IDW) < NREQ || LAT < 1 || MAX_OS < 1) begin : g_bad_params
        $error("pipe_rr_sched: illegal parameter combination");
    end

    assign tail_vld   = stg_vld[LAT-1];
    assign tail_tag   = stg_tag[LAT-1];
    assign o_pipe_en  = !tail_vld || i_rsp_rdy[tail_tag];
    assign o_rsp_vld  = tail_vld ? (NREQ'(1) << tail_tag) : '0;
    assign o_rsp_data = i_pipe_q;
    assign o_drained  = (state == ST_DRAIN) && !(|stg_vld);
    assign eligible   = i_req & ~cap_mask;
    assign grant_ok   = o_pipe_en && (state == ST_RUN) && !i_drain;
    assign o_gnt      = (grant_ok && win_found) ? (NREQ'(1) << win_idx) : '0;

    // Search upward from ptr with wrap; first eligible requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        o_pipe_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (o_gnt[k]) begin
                o_pipe_d = i_data[k*DW +: DW];
            end
        end
    end

    // Tracking shift register, pointer and RUN/DRAIN state; everything holds while stalled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stg_vld <= '0;
            for (int s = 0; s < LAT; s++) begin
                stg_tag[s] <= '0;
            end
            ptr   <= '0;
            state <= ST_RUN;
        end else begin
            if (o_pipe_en) begin
                stg_vld[0] <= |o_gnt;
                stg_tag[0] <= (|o_gnt) ? win_idx : '0;
                for (int s = 1; s < LAT; s++) begin
                    stg_vld[s] <= stg_vld[s-1];
                    stg_tag[s] <= stg_tag[s-1];
                end
            end
            if (|o_gnt) begin
                ptr <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end
            case (state)
                ST_RUN:   if (i_drain)  state <= ST_DRAIN;
                ST_DRAIN: if (!i_drain) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_SCHED_OSCAP_EN
    localparam int CW = $clog2(MAX_OS + 1);

    logic [CW-1:0]   os_cnt [NREQ];
    logic [NREQ-1:0] rsp_xfer;

    assign rsp_xfer = o_rsp_vld & i_rsp_rdy;

    // A grant and a response transfer for the same requester cancel out.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NREQ; k++) begin
            if (!i_rst_n) begin
                os_cnt[k] <= '0;
            end else if (o_gnt[k] && !rsp_xfer[k]) begin
                os_cnt[k] <= os_cnt[k] + 1'b1;
            end else if (!o_gnt[k] && rsp_xfer[k]) begin
                os_cnt[k] <= os_cnt[k] - 1'b1;
            end
        end
    end

    always_comb begin
        cap_mask = '0;
        for (int k = 0; k < NREQ; k++) begin
            cap_mask[k] = (os_cnt[k] == CW'(MAX_OS));
        end
    end
`else
    assign cap_mask = '0;
`endif

endmodule
